// File: rtl/fpga_rst_sequencer.sv
// ----------------------------------------------------------------------------
// fpga_rst_sequencer
//
// Purpose:
//   Controls the order in which the board-level resets are released for the
//   FPGA SoC. The sequence is:
//     1. Wait for the clock wizard to lock.
//     2. Pulse the DRAM controller reset.
//     3. Wait for DRAM calibration, giving up after a timeout.
//     4. Hold the SoC reset for a fixed window, then release it.
//   A debug soft-reset request re-runs the SoC hold window while the DRAM
//   keeps running. After a calibration error, the same request starts a full
//   retry from the DRAM reset pulse. Losing clock lock in any state aborts the
//   sequence and returns it to WAIT_LOCK.
//
// Parameters:
//   DramRstCycles  number of cycles dram_rst_o stays high per DRAM reset pulse
//   CalibTimeout   maximum number of cycles spent in WAIT_CALIB before ERROR
//   HoldCycles     number of cycles soc_rst_no stays low in HOLD
//   SyncStages     number of synchronizer flops on the two asynchronous inputs
//
// Ports:
//   clk_i              free-running board clock
//   rst_ni             asynchronous active-low reset
//   clk_locked_i       clock wizard lock (asynchronous, synchronized here)
//   dram_calib_done_i  DRAM calibration done (asynchronous, synchronized here)
//   sw_rst_req_i       debug soft-reset request, synchronous level;
//                      the sequencer acts on its rising edge
//   dram_rst_o         active-high DRAM controller reset
//   soc_rst_no         active-low SoC reset, high only in RUN
//   ready_o            high only in RUN
//   calib_err_o        high only in ERROR
//   state_o            current state encoding, for debug probes
// ----------------------------------------------------------------------------
module fpga_rst_sequencer #(
   parameter int unsigned DramRstCycles = 16,
   parameter int unsigned CalibTimeout  = 2**24,
   parameter int unsigned HoldCycles    = 64,
   parameter int unsigned SyncStages    = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clk_locked_i,
   input  logic       dram_calib_done_i,
   input  logic       sw_rst_req_i,
   output logic       dram_rst_o,
   output logic       soc_rst_no,
   output logic       ready_o,
   output logic       calib_err_o,
   output logic [2:0] state_o
);

   // The counter is sized for the longest of the three timed windows.
   localparam int unsigned MaxDramHold = (DramRstCycles > HoldCycles) ? DramRstCycles : HoldCycles;
   localparam int unsigned MaxCycles   = (CalibTimeout > MaxDramHold) ? CalibTimeout : MaxDramHold;
   localparam int unsigned CntW        = $clog2(MaxCycles) + 1;

   // Each timed state is loaded with (length - 1) on entry. The state then
   // lasts until the counter reaches zero, which gives exactly 'length' cycles.
   localparam logic [CntW-1:0] DramLoad  = CntW'(DramRstCycles - 1);
   localparam logic [CntW-1:0] CalibLoad = CntW'(CalibTimeout - 1);
   localparam logic [CntW-1:0] HoldLoad  = CntW'(HoldCycles - 1);
   localparam logic [CntW-1:0] CntOne    = CntW'(1);

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      DRAM_RST   = 3'd1,
      WAIT_CALIB = 3'd2,
      HOLD       = 3'd3,
      RUN        = 3'd4,
      ERROR      = 3'd5
   } state_t;

   state_t                state_reg, state_next;
   logic [CntW-1:0]       cnt_reg, cnt_next;
   logic [SyncStages-1:0] lock_sync_reg;
   logic [SyncStages-1:0] calib_sync_reg;
   logic                  sw_q_reg;
   logic                  dram_rst_reg;
   logic                  soc_rst_n_reg;
   logic                  ready_reg;
   logic                  calib_err_reg;

   logic lock_s;
   logic calib_s;
   logic sw_rise;

   // ------------------------------------------------------------------------
   // Input conditioning: shift-register synchronizers on the asynchronous
   // inputs. A registered copy of the soft-reset level is kept so that its
   // rising edge can be detected.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_sync_reg  <= '0;
         calib_sync_reg <= '0;
         sw_q_reg       <= 1'b0;
      end else begin
         lock_sync_reg  <= {lock_sync_reg[SyncStages-2:0], clk_locked_i};
         calib_sync_reg <= {calib_sync_reg[SyncStages-2:0], dram_calib_done_i};
         sw_q_reg       <= sw_rst_req_i;
      end
   end

   assign lock_s  = lock_sync_reg[SyncStages-1];
   assign calib_s = calib_sync_reg[SyncStages-1];
   assign sw_rise = sw_rst_req_i & ~sw_q_reg;

   // ------------------------------------------------------------------------
   // Next-state and counter logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;

      // Losing lock overrides everything else. The counter value does not
      // matter here, because every timed state reloads it on entry.
      if (!lock_s && (state_reg != WAIT_LOCK)) begin
         state_next = WAIT_LOCK;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_next = DRAM_RST;
                  cnt_next   = DramLoad;
               end
            end

            DRAM_RST: begin
               if (cnt_reg == '0) begin
                  state_next = WAIT_CALIB;
                  cnt_next   = CalibLoad;
               end else begin
                  cnt_next = cnt_reg - CntOne;
               end
            end

            WAIT_CALIB: begin
               // Calibration is checked before the timeout, so a completion
               // that arrives on the last allowed cycle still counts.
               if (calib_s) begin
                  state_next = HOLD;
                  cnt_next   = HoldLoad;
               end else if (cnt_reg == '0) begin
                  state_next = ERROR;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg - CntOne;
               end
            end

            HOLD: begin
               if (cnt_reg == '0) begin
                  state_next = RUN;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg - CntOne;
               end
            end

            RUN: begin
               if (!calib_s) begin
                  state_next = ERROR;
                  cnt_next   = '0;
               end else if (sw_rise) begin
                  // Soft reset: only the SoC is reset, the DRAM keeps running.
                  state_next = HOLD;
                  cnt_next   = HoldLoad;
               end
            end

            ERROR: begin
               // Only an explicit request leaves ERROR. A late calibration
               // is not trusted without a fresh DRAM reset.
               if (sw_rise) begin
                  state_next = DRAM_RST;
                  cnt_next   = DramLoad;
               end
            end

            default: begin
               // Recover from the unused encodings 6 and 7.
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State, counter and registered Moore outputs. The outputs are decoded
   // from state_next so that they change on the same edge as state_reg.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= WAIT_LOCK;
         cnt_reg       <= '0;
         dram_rst_reg  <= 1'b1;
         soc_rst_n_reg <= 1'b0;
         ready_reg     <= 1'b0;
         calib_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         dram_rst_reg  <= (state_next == WAIT_LOCK) || (state_next == DRAM_RST);
         soc_rst_n_reg <= (state_next == RUN);
         ready_reg     <= (state_next == RUN);
         calib_err_reg <= (state_next == ERROR);
      end
   end

   assign dram_rst_o  = dram_rst_reg;
   assign soc_rst_no  = soc_rst_n_reg;
   assign ready_o     = ready_reg;
   assign calib_err_o = calib_err_reg;
   assign state_o     = state_reg;

endmodule

// File: tb/tb_fpga_rst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fpga_rst_sequencer
//
// Testbench for fpga_rst_sequencer, configured with CalibTimeout = 1000.
// The DUT's progress is tracked as a series of state segments, each one a
// state plus the number of cycles spent in it. Each scenario task pushes the
// segments it expects before it drives its stimulus. The monitor pops one
// expected segment whenever the DUT closes a segment, and compares the two.
// A length of 0 in an expected segment means the length is set by the
// stimulus and is not checked.
// ----------------------------------------------------------------------------
module tb_fpga_rst_sequencer;

   localparam int unsigned DRAM_CYC  = 16;
   localparam int unsigned CAL_TO    = 1000;
   localparam int unsigned HOLD_CYC  = 64;
   localparam int unsigned SYNC_STG  = 2;

   localparam logic [2:0] S_WAIT_LOCK  = 3'd0;
   localparam logic [2:0] S_DRAM_RST   = 3'd1;
   localparam logic [2:0] S_WAIT_CALIB = 3'd2;
   localparam logic [2:0] S_HOLD       = 3'd3;
   localparam logic [2:0] S_RUN        = 3'd4;
   localparam logic [2:0] S_ERROR      = 3'd5;

   logic       clk;
   logic       rst_n;
   logic       clk_locked;
   logic       dram_calib_done;
   logic       sw_rst_req;
   logic       dram_rst;
   logic       soc_rst_n;
   logic       ready;
   logic       calib_err;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0] st;
      int         len;
   } seg_t;

   seg_t       exp_q[$];
   logic [2:0] cur_st  = 3'd0;
   int         cur_len = 0;

   fpga_rst_sequencer #(
      .DramRstCycles (DRAM_CYC),
      .CalibTimeout  (CAL_TO),
      .HoldCycles    (HOLD_CYC),
      .SyncStages    (SYNC_STG)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .clk_locked_i      (clk_locked),
      .dram_calib_done_i (dram_calib_done),
      .sw_rst_req_i      (sw_rst_req),
      .dram_rst_o        (dram_rst),
      .soc_rst_no        (soc_rst_n),
      .ready_o           (ready),
      .calib_err_o       (calib_err),
      .state_o           (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // Segment monitor and scoreboard. Sampling is done on the falling edge,
   // away from the edge where the DUT updates.
   always @(negedge clk) begin
      seg_t e;
      if (!rst_n) begin
         cur_len = 0;
      end else if (cur_len == 0) begin
         cur_st  = state;
         cur_len = 1;
      end else if (state === cur_st) begin
         cur_len++;
      end else begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL seg_unexpected: got state=%0d len=%0d, required no further segment", cur_st, cur_len);
         end else begin
            e = exp_q.pop_front();
            if ((e.st !== cur_st) || ((e.len != 0) && (e.len != cur_len))) begin
               bad++;
               $display("FAIL seg_check: got state=%0d len=%0d, required state=%0d len=%0d",
                        cur_st, cur_len, e.st, e.len);
            end else begin
               $display("seg state=%0d len=%0d ok", cur_st, cur_len);
            end
         end
         cur_st  = state;
         cur_len = 1;
      end
   end

   task automatic push_seg(input logic [2:0] st, input int len);
      seg_t s;
      s.st  = st;
      s.len = len;
      exp_q.push_back(s);
   endtask

   // Returns at the first falling edge where state equals s, or reports
   // failure once the budget of cycles is used up.
   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (state === s) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic sw_pulse();
      sw_rst_req = 1'b1;
      @(negedge clk);
      sw_rst_req = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0; clk_locked = 1'b0; dram_calib_done = 1'b0; sw_rst_req = 1'b0;
      repeat (3) @(negedge clk);
      total += 5;
      if (state !== S_WAIT_LOCK) begin bad++; $display("FAIL rst_state: got %0d, required 0", state); end
      if (dram_rst !== 1'b1) begin bad++; $display("FAIL rst_dram_rst: got %b, required 1", dram_rst); end
      if (soc_rst_n !== 1'b0) begin bad++; $display("FAIL rst_soc_rst_n: got %b, required 0", soc_rst_n); end
      if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b, required 0", ready); end
      if (calib_err !== 1'b0) begin bad++; $display("FAIL rst_calib_err: got %b, required 0", calib_err); end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if (state !== S_WAIT_LOCK || dram_rst !== 1'b1) begin
         bad++; $display("FAIL rst_no_lock_stays: got state=%0d dram_rst=%b, required 0/1", state, dram_rst);
      end
   endtask

   // Power-up sequence, with calibration arriving 100 cycles into WAIT_CALIB.
   task automatic test_power_up();
      bit ok;
      push_seg(S_WAIT_LOCK, 0);
      push_seg(S_DRAM_RST, DRAM_CYC);
      push_seg(S_WAIT_CALIB, 100);
      push_seg(S_HOLD, HOLD_CYC);
      clk_locked = 1'b1;
      wait_state(S_WAIT_CALIB, 100, ok);
      // The input takes SyncStages cycles to pass the synchronizer, plus one
      // more for the transition.
      repeat (97) @(negedge clk);
      dram_calib_done = 1'b1;
      wait_state(S_RUN, 300, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL pu_reach_run: got state=%0d, required 4", state); end
      total += 4;
      if (ready !== 1'b1) begin bad++; $display("FAIL pu_ready: got %b, required 1", ready); end
      if (soc_rst_n !== 1'b1) begin bad++; $display("FAIL pu_soc_rst_n: got %b, required 1", soc_rst_n); end
      if (dram_rst !== 1'b0) begin bad++; $display("FAIL pu_dram_rst: got %b, required 0", dram_rst); end
      if (calib_err !== 1'b0) begin bad++; $display("FAIL pu_calib_err: got %b, required 0", calib_err); end
      repeat (2) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL pu_pending: got %0d segments left, required 0", exp_q.size()); end
   endtask

   // A soft-reset request held high for 500 cycles produces a single HOLD.
   task automatic test_sw_held();
      int         hold_entries = 0;
      bit         dram_seen    = 1'b0;
      logic [2:0] prev_st;
      push_seg(S_RUN, 0);
      push_seg(S_HOLD, HOLD_CYC);
      prev_st    = state;
      sw_rst_req = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (state === S_HOLD && prev_st !== S_HOLD) hold_entries++;
         if (dram_rst !== 1'b0) dram_seen = 1'b1;
         prev_st = state;
      end
      sw_rst_req = 1'b0;
      repeat (4) @(negedge clk);
      total += 4;
      if (hold_entries != 1) begin bad++; $display("FAIL sw_hold_count: got %0d, required 1", hold_entries); end
      if (dram_seen) begin bad++; $display("FAIL sw_dram_rst: got high during soft reset, required 0"); end
      if (state !== S_RUN) begin bad++; $display("FAIL sw_back_run: got %0d, required 4", state); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL sw_pending: got %0d segments left, required 0", exp_q.size()); end
   endtask

   // Losing calibration in RUN leads to ERROR. Calibration coming back alone
   // does not leave ERROR; a soft-reset request does.
   task automatic test_calib_loss();
      int n = 0;
      bit ok;
      push_seg(S_RUN, 0);
      push_seg(S_ERROR, 0);
      push_seg(S_DRAM_RST, DRAM_CYC);
      push_seg(S_WAIT_CALIB, 1);
      push_seg(S_HOLD, HOLD_CYC);
      dram_calib_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n++;
         if (state === S_ERROR) break;
      end
      total += 3;
      if (n != SYNC_STG + 1) begin bad++; $display("FAIL cl_latency: got %0d cycles, required %0d", n, SYNC_STG + 1); end
      if (calib_err !== 1'b1) begin bad++; $display("FAIL cl_calib_err: got %b, required 1", calib_err); end
      if (soc_rst_n !== 1'b0 || ready !== 1'b0) begin
         bad++; $display("FAIL cl_soc_off: got soc_rst_n=%b ready=%b, required 0/0", soc_rst_n, ready);
      end
      dram_calib_done = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (state !== S_ERROR) begin bad++; $display("FAIL cl_stay_error: got %0d, required 5", state); end
      sw_pulse();
      wait_state(S_RUN, 200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL cl_retry_run: got state=%0d, required 4", state); end
      repeat (2) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL cl_pending: got %0d segments left, required 0", exp_q.size()); end
   endtask

   // WAIT_CALIB times out after exactly CAL_TO cycles. A retry then gives a
   // DRAM reset pulse of exactly DRAM_CYC cycles.
   task automatic test_calib_timeout();
      int dram_cnt = 0;
      bit ok;
      push_seg(S_RUN, 0);
      push_seg(S_ERROR, 0);
      push_seg(S_DRAM_RST, DRAM_CYC);
      push_seg(S_WAIT_CALIB, CAL_TO);
      dram_calib_done = 1'b0;
      wait_state(S_ERROR, 10, ok);
      sw_pulse();
      wait_state(S_WAIT_CALIB, 40, ok);
      wait_state(S_ERROR, CAL_TO + 20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL to_reach_error: got state=%0d, required 5", state); end
      total += 3;
      if (calib_err !== 1'b1) begin bad++; $display("FAIL to_calib_err: got %b, required 1", calib_err); end
      if (soc_rst_n !== 1'b0) begin bad++; $display("FAIL to_soc_rst_n: got %b, required 0", soc_rst_n); end
      if (dram_rst !== 1'b0) begin bad++; $display("FAIL to_dram_rst: got %b, required 0", dram_rst); end
      push_seg(S_ERROR, 0);
      push_seg(S_DRAM_RST, DRAM_CYC);
      push_seg(S_WAIT_CALIB, 3);
      push_seg(S_HOLD, HOLD_CYC);
      repeat (5) @(negedge clk);
      sw_pulse();
      for (int i = 0; i < 40 && dram_rst === 1'b1; i++) begin
         dram_cnt++;
         @(negedge clk);
      end
      total++;
      if (dram_cnt != DRAM_CYC) begin bad++; $display("FAIL to_dram_pulse: got %0d cycles, required %0d", dram_cnt, DRAM_CYC); end
      dram_calib_done = 1'b1;
      wait_state(S_RUN, 200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL to_retry_run: got state=%0d, required 4", state); end
      repeat (2) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL to_pending: got %0d segments left, required 0", exp_q.size()); end
   endtask

   // Lock dropped for 5 cycles, first in RUN and then in the middle of HOLD.
   task automatic test_lock_loss();
      int seen = 0;
      bit wl_dram_bad = 1'b0;
      bit ok;
      push_seg(S_RUN, 0);
      push_seg(S_WAIT_LOCK, 5);
      push_seg(S_DRAM_RST, DRAM_CYC);
      push_seg(S_WAIT_CALIB, 1);
      push_seg(S_HOLD, 13);
      push_seg(S_WAIT_LOCK, 5);
      push_seg(S_DRAM_RST, DRAM_CYC);
      push_seg(S_WAIT_CALIB, 1);
      push_seg(S_HOLD, HOLD_CYC);
      clk_locked = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (state === S_WAIT_LOCK && seen == 0) begin
            seen = i;
            if (dram_rst !== 1'b1 || soc_rst_n !== 1'b0) wl_dram_bad = 1'b1;
         end
      end
      clk_locked = 1'b1;
      total += 2;
      if (seen != SYNC_STG + 1) begin bad++; $display("FAIL ll_latency: got %0d cycles, required %0d", seen, SYNC_STG + 1); end
      if (wl_dram_bad) begin bad++; $display("FAIL ll_outputs: got wrong dram_rst/soc_rst_n in WAIT_LOCK, required 1/0"); end
      wait_state(S_HOLD, 100, ok);
      repeat (10) @(negedge clk);
      clk_locked = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (state !== S_WAIT_LOCK || dram_rst !== 1'b1) begin
         bad++; $display("FAIL ll_hold_abort: got state=%0d dram_rst=%b, required 0/1", state, dram_rst);
      end
      clk_locked = 1'b1;
      wait_state(S_RUN, 200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ll_rerun: got state=%0d, required 4", state); end
      repeat (2) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL ll_pending: got %0d segments left, required 0", exp_q.size()); end
   endtask

   // Asynchronous reset during WAIT_CALIB, followed by calibration arriving
   // on the last cycle before the timeout.
   task automatic test_async_reset_boundary();
      bit ok;
      push_seg(S_RUN, 0);
      push_seg(S_ERROR, 0);
      push_seg(S_DRAM_RST, DRAM_CYC);
      dram_calib_done = 1'b0;
      wait_state(S_ERROR, 10, ok);
      sw_pulse();
      wait_state(S_WAIT_CALIB, 40, ok);
      repeat (50) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL ar_pending: got %0d segments left, required 0", exp_q.size()); end
      #2 rst_n = 1'b0;
      #1;
      total += 5;
      if (state !== S_WAIT_LOCK) begin bad++; $display("FAIL ar_state: got %0d, required 0", state); end
      if (dram_rst !== 1'b1) begin bad++; $display("FAIL ar_dram_rst: got %b, required 1", dram_rst); end
      if (soc_rst_n !== 1'b0) begin bad++; $display("FAIL ar_soc_rst_n: got %b, required 0", soc_rst_n); end
      if (ready !== 1'b0) begin bad++; $display("FAIL ar_ready: got %b, required 0", ready); end
      if (calib_err !== 1'b0) begin bad++; $display("FAIL ar_calib_err: got %b, required 0", calib_err); end
      repeat (3) @(negedge clk);
      push_seg(S_WAIT_LOCK, 0);
      push_seg(S_DRAM_RST, DRAM_CYC);
      push_seg(S_WAIT_CALIB, CAL_TO);
      push_seg(S_HOLD, HOLD_CYC);
      rst_n = 1'b1;
      wait_state(S_WAIT_CALIB, 100, ok);
      // With this timing, calib_s first reads 1 in the cycle where the
      // counter reaches zero.
      repeat (CAL_TO - 3) @(negedge clk);
      dram_calib_done = 1'b1;
      wait_state(S_RUN, 200, ok);
      total++;
      if (!ok || ready !== 1'b1) begin bad++; $display("FAIL ar_boundary_run: got state=%0d ready=%b, required 4/1", state, ready); end
      repeat (2) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL ar_pending2: got %0d segments left, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_sw_held();
      test_calib_loss();
      test_calib_timeout();
      test_lock_loss();
      test_async_reset_boundary();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
